program_loader: RTL



---
 rtl/nibble_pkg.sv | 29 ++
 rtl/program_loader.sv | 136 +++++++++++++
 2 files changed

// File: rtl/nibble_pkg.sv
// Shared definitions for the instruction-store loader: FSM states,
// frame geometry and instruction field positions.
package nibble_pkg;

    localparam int WORD_BYTES = 3;
    localparam int MAX_WORDS  = 32;

    localparam int OP_HI   = 23;
    localparam int OP_LO   = 21;
    localparam int ADDR_HI = 20;
    localparam int ADDR_LO = 16;
    localparam int X_HI    = 15;
    localparam int X_LO    = 8;
    localparam int Y_HI    = 7;
    localparam int Y_LO    = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_B2,
        ST_B1,
        ST_B0,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } load_state_t;

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: receives a framed byte stream, packs it into
// 24-bit instruction words, writes them to consecutive instruction memory
// addresses and keeps the processor in reset until a good frame is loaded.
module program_loader
    import nibble_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 24,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    load_state_t       state;
    load_state_t       state_next;
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic [7:0]        sum;
    logic              accept;
    logic              hdr_ok;
    logic              last_word;

    assign accept    = in_valid && in_ready;
    assign hdr_ok    = (in_data != 8'd0) && (32'(in_data) <= 32'(DEPTH));
    assign last_word = ({1'b0, addr} == (count - 1'b1));
    assign wr_addr   = addr;
    assign wr_data   = word;

    // State register, returns to IDLE immediately on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; load_req is only honoured from IDLE and ERR.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (load_req) state_next = ST_HDR;
            ST_HDR:   if (accept) state_next = hdr_ok ? ST_B2 : ST_ERR;
            ST_B2:    if (accept) state_next = ST_B1;
            ST_B1:    if (accept) state_next = ST_B0;
            ST_B0:    if (accept) state_next = ST_WRITE;
            ST_WRITE: state_next = last_word ? ST_CSUM : ST_B2;
            ST_CSUM:  if (accept) state_next = (in_data == sum) ? ST_DONE : ST_ERR;
            ST_DONE:  state_next = ST_IDLE;
            ST_ERR:   if (load_req) state_next = ST_HDR;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded purely from the current state.
    always_comb begin
        in_ready = 1'b0;
        wr_en    = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_hold = 1'b1;
        unique case (state)
            ST_IDLE:  cpu_hold = 1'b0;
            ST_HDR:   in_ready = 1'b1;
            ST_B2:    in_ready = 1'b1;
            ST_B1:    in_ready = 1'b1;
            ST_B0:    in_ready = 1'b1;
            ST_WRITE: wr_en    = 1'b1;
            ST_CSUM:  in_ready = 1'b1;
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ST_ERR:   err = 1'b1;
            default:  cpu_hold = 1'b0;
        endcase
    end

    // Datapath: word assembly, checksum accumulation, word count and address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word  <= '0;
            addr  <= '0;
            count <= '0;
            sum   <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_ERR: begin
                    if (load_req) begin
                        addr <= '0;
                        sum  <= '0;
                    end
                end
                ST_HDR: begin
                    if (accept) count <= in_data[ADDR_W:0];
                end
                ST_B2: begin
                    if (accept) begin
                        word[23:16] <= in_data;
                        sum         <= sum + in_data;
                    end
                end
                ST_B1: begin
                    if (accept) begin
                        word[X_HI:X_LO] <= in_data;
                        sum             <= sum + in_data;
                    end
                end
                ST_B0: begin
                    if (accept) begin
                        word[Y_HI:Y_LO] <= in_data;
                        sum             <= sum + in_data;
                    end
                end
                ST_WRITE: begin
                    if (!last_word) addr <= addr + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
